// File: rtl/prog_run_ctrl.sv
// Run sequencer: accepts a host Start, holds the core in reset, pulses its start, counts RUN cycles until halt, then Acks.
// Optional watchdog abort is compiled in with `define PROG_RUN_WATCHDOG_EN.
module prog_run_ctrl #(
  parameter int PW          = 10,
  parameter int NPROG       = 4,
  parameter int PSW         = (NPROG > 1) ? $clog2(NPROG) : 1,
  parameter int PROG_STRIDE = 256,
  parameter int RST_CYCLES  = 2,
  parameter int CW          = 16
`ifdef PROG_RUN_WATCHDOG_EN
  ,
  parameter int MAX_CYCLES  = 50000
`endif
) (
  input  logic          i_clk,
  input  logic          i_reset_n,
  input  logic          i_start,
  input  logic [PSW-1:0] i_prog_sel,
  input  logic          i_core_halt,
  output logic          o_core_reset,
  output logic          o_core_start,
  output logic [PW-1:0] o_start_target,
  output logic          o_ack,
  output logic          o_busy,
  output logic [CW-1:0] o_cycle_ct,
  output logic          o_timed_out
);

  // state  | meaning
  // IDLE   | core held in reset, waiting for Start
  // HOLD   | core reset held for RST_CYCLES cycles
  // LAUNCH | core released, single-cycle start pulse
  // RUN    | counting cycles until halt (or watchdog)
  // DONE   | Ack held, results frozen, Start relaunches
  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_HOLD   = 3'd1;
  localparam logic [2:0] S_LAUNCH = 3'd2;
  localparam logic [2:0] S_RUN    = 3'd3;
  localparam logic [2:0] S_DONE   = 3'd4;

  localparam int             HCW       = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
  localparam logic [HCW-1:0] HOLD_LOAD = HCW'(RST_CYCLES - 1);

`ifdef PROG_RUN_WATCHDOG_EN
  localparam logic [CW-1:0] WD_LAST  = CW'(MAX_CYCLES - 1);
  localparam logic [CW-1:0] WD_LIMIT = CW'(MAX_CYCLES);
`endif

  logic [2:0]     r_state;
  logic [HCW-1:0] r_hold_cnt;
  logic           r_core_reset;
  logic           r_core_start;
  logic [PW-1:0]  r_start_target;
  logic           r_ack;
  logic           r_busy;
  logic [CW-1:0]  r_cycle_ct;
  logic [PW-1:0]  w_entry;
  logic           w_accept;

  // Entry PC wraps modulo 2**PW by truncation.
  assign w_entry  = PW'(32'(i_prog_sel) * 32'(PROG_STRIDE));
  assign w_accept = i_start && ((r_state == S_IDLE) || (r_state == S_DONE));

  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      r_state        <= S_IDLE;
      r_hold_cnt     <= '0;
      r_core_reset   <= 1'b1;
      r_core_start   <= 1'b0;
      r_start_target <= '0;
      r_ack          <= 1'b0;
      r_busy         <= 1'b0;
      r_cycle_ct     <= '0;
    end else begin
      r_core_start <= 1'b0;
      case (r_state)
        S_IDLE, S_DONE: begin
          if (w_accept) begin
            r_state        <= S_HOLD;
            r_start_target <= w_entry;
            r_hold_cnt     <= HOLD_LOAD;
            r_ack          <= 1'b0;
            r_busy         <= 1'b1;
            r_core_reset   <= 1'b1;
          end
        end
        S_HOLD: begin
          if (r_hold_cnt == '0) begin
            r_state      <= S_LAUNCH;
            r_core_reset <= 1'b0;
            r_core_start <= 1'b1;
            r_cycle_ct   <= '0;
          end else begin
            r_hold_cnt <= r_hold_cnt - 1'b1;
          end
        end
        S_LAUNCH: begin
          r_state <= S_RUN;
        end
        S_RUN: begin
          if (i_core_halt) begin
            r_state      <= S_DONE;
            r_ack        <= 1'b1;
            r_busy       <= 1'b0;
            r_core_reset <= 1'b1;
`ifdef PROG_RUN_WATCHDOG_EN
          end else if (r_cycle_ct == WD_LAST) begin
            r_state      <= S_DONE;
            r_ack        <= 1'b1;
            r_busy       <= 1'b0;
            r_core_reset <= 1'b1;
            r_cycle_ct   <= WD_LIMIT;
`endif
          end else if (r_cycle_ct != '1) begin
            r_cycle_ct <= r_cycle_ct + 1'b1;
          end
        end
        default: begin
          r_state      <= S_IDLE;
          r_core_reset <= 1'b1;
          r_busy       <= 1'b0;
          r_ack        <= 1'b0;
        end
      endcase
    end
  end

`ifdef PROG_RUN_WATCHDOG_EN
  logic r_timed_out;

  // Set only on the watchdog exit; a halt on that same cycle takes the first branch.
  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      r_timed_out <= 1'b0;
    end else if (w_accept) begin
      r_timed_out <= 1'b0;
    end else if ((r_state == S_RUN) && !i_core_halt && (r_cycle_ct == WD_LAST)) begin
      r_timed_out <= 1'b1;
    end
  end

  assign o_timed_out = r_timed_out;
`else
  assign o_timed_out = 1'b0;
`endif

  assign o_core_reset   = r_core_reset;
  assign o_core_start   = r_core_start;
  assign o_start_target = r_start_target;
  assign o_ack          = r_ack;
  assign o_busy         = r_busy;
  assign o_cycle_ct     = r_cycle_ct;

endmodule
